hidden_cpu_feeder: RTL

HIDDEN_CPU_FEEDER -- requirements
Module: hidden_cpu_feeder

---
 rtl/hidden_feeder_pkg.sv | 37 +++
 rtl/hidden_cpu_feeder_if.sv | 23 ++
 rtl/feeder_prog_buf.sv | 24 ++
 rtl/hidden_cpu_feeder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/hidden_feeder_pkg.sv
// Shared types and constants for the hidden CPU feeder.
// Pin map of the driven CPU: [0] clock, [1] reset, [7:2] instruction.
package hidden_feeder_pkg;

    localparam int DEPTH     = 16;
    localparam int INSTR_W   = 6;
    localparam int AW        = 4;
    localparam int CW        = 5;
    localparam int CLK_BIT   = 0;
    localparam int RST_BIT   = 1;
    localparam int INSTR_LSB = 2;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RST_LO,
        RST_HI,
        RUN_LO,
        RUN_HI,
        DONE
    } state_t;

    function automatic logic [7:0] pins(
        input logic [INSTR_W-1:0] instr,
        input logic               cclk,
        input logic               crst
    );
        logic [7:0] p;
        p                   = '0;
        p[7:INSTR_LSB]      = instr;
        p[CLK_BIT]          = cclk;
        p[RST_BIT]          = crst;
        return p;
    endfunction

endpackage

// File: rtl/hidden_cpu_feeder_if.sv
// Host-side program load handshake for the hidden CPU feeder.
// The host is the master; the feeder is the slave.
interface hidden_cpu_feeder_if
    import hidden_feeder_pkg::*;
();

    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/feeder_prog_buf.sv
// 16x6 program store: one write port, one combinational read port.
// Storage is deliberately not reset.
module feeder_prog_buf
    import hidden_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hidden_cpu_feeder.sv
// Loads a short program, then clocks it into a pin-driven CPU once.
// Define HIDDEN_FEEDER_LOOP_EN to add the 'loop' port for repeated passes.
module hidden_cpu_feeder
    import hidden_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    hidden_cpu_feeder_if.slave  ld,
    input  logic                clear,
    input  logic                start,
`ifdef HIDDEN_FEEDER_LOOP_EN
    input  logic                loop,
`endif
    output logic                busy,
    output logic                done,
    output logic [7:0]          cpu_io_in,
    input  logic [7:0]          cpu_io_out,
    output logic [7:0]          result
);

    state_t             state;
    logic [CW-1:0]      count;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               load_ready;
    logic               accept;
    logic               last;
    logic               loop_on;

`ifdef HIDDEN_FEEDER_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    assign ld.load_ready = load_ready;
    assign accept = (state == IDLE) && ld.load_valid && load_ready && !clear;
    assign last   = ({1'b0, idx} == count - 5'd1);

    // Address the word the next state will present, so the pins stay registered.
    always_comb begin
        rd_addr = idx;
        case (state)
            RST_HI: rd_addr = '0;
            RUN_HI: begin
                if (!last) begin
                    rd_addr = idx + 4'd1;
                end else if (loop_on) begin
                    rd_addr = '0;
                end
            end
            default: rd_addr = idx;
        endcase
    end

    feeder_prog_buf u_buf (
        .clk     (clk),
        .we      (accept),
        .wr_addr (count[AW-1:0]),
        .wr_data (ld.load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            result     <= '0;
            cpu_io_in  <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        count      <= '0;
                        load_ready <= 1'b1;
                    end else if (accept) begin
                        count      <= count + 5'd1;
                        load_ready <= (count != FULL - 5'd1);
                    end else if (start && count != '0) begin
                        state      <= RST_LO;
                        idx        <= '0;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        cpu_io_in  <= pins('0, 1'b0, 1'b1);
                    end
                end
                RST_LO: begin
                    state     <= RST_HI;
                    cpu_io_in <= pins('0, 1'b1, 1'b1);
                end
                RST_HI: begin
                    state     <= RUN_LO;
                    idx       <= '0;
                    cpu_io_in <= pins(rd_data, 1'b0, 1'b0);
                end
                RUN_LO: begin
                    state     <= RUN_HI;
                    cpu_io_in <= pins(rd_data, 1'b1, 1'b0);
                end
                RUN_HI: begin
                    result    <= cpu_io_out;
                    cpu_io_in <= pins(rd_data, 1'b0, 1'b0);
                    if (!last) begin
                        state <= RUN_LO;
                        idx   <= idx + 4'd1;
                    end else if (loop_on) begin
                        state <= RUN_LO;
                        idx   <= '0;
                    end else begin
                        state <= DONE;
                        idx   <= idx + 4'd1;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cpu_io_in  <= '0;
                    load_ready <= (count != FULL);
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cpu_io_in  <= '0;
                    load_ready <= (count != FULL);
                end
            endcase
        end
    end

endmodule
